// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters.
// Operands are registered, one op in flight, result returned with its tag.
module alu (
    input  logic [1:0]  alu_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_out
);
    always_comb begin
        alu_out = '0;
        unique case (alu_sel)
            2'b00: alu_out = a;
            2'b01: alu_out = a + b;
            2'b10: alu_out = a - b;
            2'b11: alu_out = '0;
            default: alu_out = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_data,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_data,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             rr_last;
    logic             owner;
    logic [1:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      alu_out;
    logic             win0, win1;
    logic             accept;
    logic             rsp_done;

    alu u_alu (
        .alu_sel (op_q),
        .a       (a_q),
        .b       (b_q),
        .alu_out (alu_out)
    );

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win0       = req0_valid && (!req1_valid || rr_last);
        win1       = req1_valid && (!req0_valid || !rr_last);
        req0_ready = (state_q == IDLE) && win0;
        req1_ready = (state_q == IDLE) && win1;
        accept     = req0_ready || req1_ready;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        busy       = (state_q != IDLE);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_last    <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_tag   <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_tag   <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner   <= req1_ready;
                rr_last <= req1_ready;
                op_q    <= req1_ready ? req1_op  : req0_op;
                a_q     <= req1_ready ? req1_a   : req0_a;
                b_q     <= req1_ready ? req1_b   : req0_b;
                tag_q   <= req1_ready ? req1_tag : req0_tag;
            end
            if (req0_ready && grant_cnt0 != '1)
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (req1_ready && grant_cnt1 != '1)
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            if (state_q == EXEC) begin
                if (owner) begin
                    rsp1_valid <= 1'b1;
                    rsp1_data  <= alu_out;
                    rsp1_tag   <= tag_q;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_data  <= alu_out;
                    rsp0_tag   <= tag_q;
                end
            end
            if (state_q == RESP && rsp_done) begin
                if (owner) rsp1_valid <= 1'b0;
                else       rsp0_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-level model.
// A second instance with 2-bit counters exercises saturation.
module tb_alu_arbiter;
    localparam int TAG_W = 4;

    logic             clk, rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [31:0]      rsp0_data, rsp1_data;
    logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
    logic             busy;
    logic [15:0]      grant_cnt0, grant_cnt1;

    logic             s_req0_ready, s_req1_ready;
    logic             s_rsp0_valid, s_rsp1_valid;
    logic [31:0]      s_rsp0_data, s_rsp1_data;
    logic [TAG_W-1:0] s_rsp0_tag, s_rsp1_tag;
    logic             s_busy;
    logic [1:0]       s_cnt0, s_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    bit rr_last_m;
    int cnt_m [2];

    alu_arbiter #(.TAG_W(TAG_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
        .busy(busy),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_arbiter #(.TAG_W(TAG_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_tag(req1_tag),
        .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(s_rsp0_data), .rsp0_tag(s_rsp0_tag),
        .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(s_rsp1_data), .rsp1_tag(s_rsp1_tag),
        .busy(s_busy),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic int winner(input bit v0, input bit v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        return rr_last_m ? 0 : 1;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            2'd0: return a;
            2'd1: return a + b;
            2'd2: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_rdy(input int idx, input bit v);
        if (idx == 0) rsp0_ready = v;
        else          rsp1_ready = v;
    endtask

    task automatic check_counts();
        chk("grant_cnt0", grant_cnt0, sat(cnt_m[0], 65535));
        chk("grant_cnt1", grant_cnt1, sat(cnt_m[1], 65535));
        chk("sat_cnt0", s_cnt0, sat(cnt_m[0], 3));
        chk("sat_cnt1", s_cnt1, sat(cnt_m[1], 3));
    endtask

    task automatic check_zero();
        chk("zero_busy", busy, 0);
        chk("zero_rsp0_valid", rsp0_valid, 0);
        chk("zero_rsp1_valid", rsp1_valid, 0);
        chk("zero_rsp0_data", rsp0_data, 0);
        chk("zero_rsp1_data", rsp1_data, 0);
        chk("zero_rsp0_tag", rsp0_tag, 0);
        chk("zero_rsp1_tag", rsp1_tag, 0);
        check_counts();
    endtask

    // Called and returns at a negedge with the block idle.
    task automatic do_reset();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        rr_last_m = 1;
        cnt_m[0] = 0; cnt_m[1] = 0;
        check_zero();
    endtask

    // Called and returns at a negedge with the block idle.
    task automatic do_op(input bit v0, input bit v1,
                         input logic [1:0] o0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic [3:0] t0,
                         input logic [1:0] o1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [3:0] t1,
                         input int bp);
        int w;
        logic [31:0] ed;
        logic [3:0]  et;
        req0_valid = v0; req0_op = o0; req0_a = a0;
        req0_b = b0; req0_tag = t0;
        req1_valid = v1; req1_op = o1; req1_a = a1;
        req1_b = b1; req1_tag = t1;
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        w  = winner(v0, v1);
        ed = (w == 1) ? alu_ref(o1, a1, b1) : alu_ref(o0, a0, b0);
        et = (w == 1) ? t1 : t0;
        chk("req0_ready", req0_ready, (w == 0));
        chk("req1_ready", req1_ready, (w == 1));
        chk("idle_busy", busy, 0);
        @(posedge clk);
        rr_last_m = (w == 1);
        cnt_m[w]++;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
        chk("exec_busy", busy, 1);
        chk("exec_rsp0_valid", rsp0_valid, 0);
        chk("exec_rsp1_valid", rsp1_valid, 0);
        check_counts();
        @(posedge clk);
        @(negedge clk);
        chk("rsp0_valid", rsp0_valid, (w == 0));
        chk("rsp1_valid", rsp1_valid, (w == 1));
        chk("rsp_data", (w == 1) ? rsp1_data : rsp0_data, ed);
        chk("rsp_tag", (w == 1) ? rsp1_tag : rsp0_tag, et);
        for (int i = 0; i < bp; i++) begin
            if (w == 1) req0_valid = 1; else req1_valid = 1;
            set_rdy(1 - w, 1'($urandom));
            #1;
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", (w == 1) ? rsp1_valid : rsp0_valid, 1);
            chk("bp_other_valid", (w == 1) ? rsp0_valid : rsp1_valid, 0);
            chk("bp_data", (w == 1) ? rsp1_data : rsp0_data, ed);
            chk("bp_tag", (w == 1) ? rsp1_tag : rsp0_tag, et);
            chk("bp_busy", busy, 1);
        end
        req0_valid = 0; req1_valid = 0;
        set_rdy(w, 1);
        set_rdy(1 - w, 1'($urandom));
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        chk("done_rsp0_valid", rsp0_valid, 0);
        chk("done_rsp1_valid", rsp1_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    task automatic rnd_op(input bit v0, input bit v1, input int bp);
        do_op(v0, v1,
              2'($urandom), pick32(), pick32(), 4'($urandom),
              2'($urandom), pick32(), pick32(), 4'($urandom), bp);
    endtask

    // Reset while an op is in EXEC (stage 0) or RESP (stage 1).
    task automatic reset_mid(input int stage);
        req0_valid = 1; req0_op = 2'd1; req0_a = 32'd9;
        req0_b = 32'd9; req0_tag = 4'd5;
        req1_valid = 0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        if (stage == 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_rsp0_valid", rsp0_valid, 0);
            chk("post_rst_rsp1_valid", rsp1_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
    endtask

    initial begin
        rst = 1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        do_op(1, 0, 2'd1, 32'd5, 32'd7, 4'd3,
              2'd0, 32'd0, 32'd0, 4'd0, 0);

        do_reset();
        rnd_op(1, 1, 0);
        rnd_op(1, 1, 0);
        rnd_op(1, 1, 0);
        chk("three_ops_cnt0", grant_cnt0, 2);
        chk("three_ops_cnt1", grant_cnt1, 1);

        do_op(1, 0, 2'd2, 32'd0, 32'd1, 4'd1,
              2'd0, 32'd0, 32'd0, 4'd0, 0);
        do_op(1, 0, 2'd1, 32'hFFFF_FFFF, 32'd1, 4'd2,
              2'd0, 32'd0, 32'd0, 4'd0, 0);
        do_op(1, 0, 2'd3, 32'h1234, 32'd77, 4'd4,
              2'd0, 32'd0, 32'd0, 4'd0, 0);
        do_op(0, 1, 2'd0, 32'd0, 32'd0, 4'd0,
              2'd0, 32'hDEAD_BEEF, 32'd3, 4'd15, 0);

        do_op(0, 1, 2'd0, 32'd0, 32'd0, 4'd0,
              2'd1, 32'd100, 32'd23, 4'd9, 5);
        do_op(1, 0, 2'd2, 32'd50, 32'd8, 4'd6,
              2'd0, 32'd0, 32'd0, 4'd0, 0);

        reset_mid(0);
        rnd_op(1, 1, 0);
        reset_mid(1);
        rnd_op(0, 1, 0);

        do_reset();
        for (int i = 0; i < 5; i++) rnd_op(1, 0, 0);
        chk("sat_cnt0_stuck", s_cnt0, 3);
        chk("full_cnt0_five", grant_cnt0, 5);

        for (int i = 0; i < 150; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rnd_op(pat[0], pat[1], $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit `alu` block between two independent requesters.
- `alu` ops: 00 = pass A, 01 = A+B, 10 = A-B, 11 = clear.
- The block arbitrates round-robin, registers operands, sequences one ALU operation at a time, and returns the result with the requester's tag over a valid/ready response channel.
- It sits between the core's two issue ports and the shared ALU, and keeps per-requester grant counters for performance monitoring.

Parameters:
TAG_W, 4, width of the request/response tag carried alongside each operation.
CNT_W, 16, width of each saturating per-requester grant counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
reqN_valid  input  1  requester N (N=0,1) has an operation pending.
reqN_ready  output  1  block accepts requester N's operation this cycle.
reqN_op  input  2  ALU select for requester N.
reqN_a  input  32  operand A.
reqN_b  input  32  operand B.
reqN_tag  input  TAG_W  opaque tag, returned unchanged.
rspN_valid  output  1  result for requester N available.
rspN_ready  input  1  requester N consumes the result.
rspN_data  output  32  ALU result.
rspN_tag  output  TAG_W  tag of the completed operation.
busy  output  1  high whenever the FSM is not in IDLE.
grant_cntN  output  CNT_W  number of accepted operations from requester N, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; rr_last = 1, so requester 0 wins the first tie.
  - All rspN_valid = 0, rspN_data = 0, rspN_tag = 0, busy = 0, grant_cntN = 0.
  - Reset mid-operation discards the in-flight operation; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, only for the winner, never both.
  - Winner rule: if only one valid, that requester wins. If both valid, the requester not equal to rr_last wins.
  - On handshake (valid & ready): latch op, a, b, tag and owner; set rr_last = owner; increment grant_cnt[owner] unless it equals all-ones; next state EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - ALU is driven from the latched operands and op; ALU_Out is registered into rsp[owner]_data, tag into rsp[owner]_tag.
  - rsp[owner]_valid is set; next state RESP.
- RESP:
  - rsp[owner]_valid stays high; data and tag are held stable until rsp[owner]_ready=1.
  - On that edge: valid clears; next state IDLE.
  - The other response channel stays valid=0 throughout.
- Latency and throughput:
  - Accept edge to rspN_valid high: 2 edges.
  - Minimum issue interval: 3 cycles per operation (IDLE → EXEC → RESP with same-cycle ready).
- Arithmetic: modulo 2^32, no flags, no carry out. 0 - 1 = 0xFFFFFFFF; 0xFFFFFFFF + 1 = 0.
- Simultaneous events:
  - reqN_valid rising while the block is in EXEC or RESP is ignored until IDLE; ready stays 0.
  - Requesters must hold valid and payload until ready; the block does not depend on this beyond the accept cycle.
- Idle operand gating: when the FSM is idle, ALU inputs are don't-care; outputs depend only on registered state.

Test Plan:
- Reset, then req0 only (op=01, a=5, b=7, tag=3): req0_ready=1 on cycle 0; rsp0_valid=1 two edges later with data=12, tag=3; rsp1_valid stays 0.
- Both valid in IDLE straight after reset, then repeatedly with rsp ready held high:
  - First grant goes to 0, then 1, then 0 (strict alternation).
  - grant_cnt0=2 and grant_cnt1=1 after three ops.
- Wrap-around and ops:
  - op=10, a=0, b=1 → 0xFFFFFFFF.
  - op=01, a=0xFFFFFFFF, b=1 → 0.
  - op=11, a=0x1234 → 0.
  - op=00, a=0xDEADBEEF → 0xDEADBEEF.
- Backpressure: rsp1_ready=0 for 5 cycles after rsp1_valid:
  - valid, data and tag are held constant; busy=1; req0_ready stays 0 throughout.
  - Release → IDLE next cycle, then req0 is granted.
- Reset asserted during EXEC:
  - No rsp_valid follows; all outputs zero next cycle.
  - A fresh req1 after reset is granted only if req0 is not valid (rr_last=1).
- Counter saturation (CNT_W=2): issue 5 req0 ops → grant_cnt0 sticks at 3; no wrap.
